seq_divider8: RTL and testbench

Multi-cycle unsigned restoring divider that inverts the datapath's ripple-carry adder direction: it computes quotient and remainder by repeated trial subtraction, one quotient bit per clock. It sits beside the 8-bit adder in the arithmetic lab datapath and is driven by a start/done handshake from the control sequencer. The block resolves divide-by-zero in a fixed, short path.

---
 rtl/arith_pkg.sv | 12 +
 rtl/fsub.sv | 13 +
 rtl/seq_divider8.sv | 127 ++++++++++++
 tb/tb_seq_divider8.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-lab definitions: divider FSM states and default operand width.
package arith_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/fsub.sv
// One-bit full subtractor: diff = x - y - bin, with borrow out.
module fsub (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/seq_divider8.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_divider8
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int               CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_e       state_q;
    logic [WIDTH-1:0] den_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic [WIDTH:0]   trial_x_s;
    logic [WIDTH:0]   trial_y_s;
    logic [WIDTH:0]   trial_diff_s;
    logic [WIDTH+1:0] borrow_s;
    logic             negative_s;
    logic             zero_div_s;

    // The shifted-out quotient MSB extends R so 2R+1 never overflows the trial.
    assign trial_x_s   = {rem_q, quo_q[WIDTH-1]};
    assign trial_y_s   = {1'b0, den_q};
    assign borrow_s[0] = 1'b0;

    genvar i;
    generate
        for (i = 0; i <= WIDTH; i++) begin : g_borrow_chain
            fsub u_fsub (
                .x    (trial_x_s[i]),
                .y    (trial_y_s[i]),
                .bin  (borrow_s[i]),
                .diff (trial_diff_s[i]),
                .bout (borrow_s[i+1])
            );
        end
    endgenerate

    // Either the final borrow or the trial sign bit marks a failed subtraction.
    assign negative_s = borrow_s[WIDTH+1] | trial_diff_s[WIDTH];
    assign zero_div_s = (divisor == {WIDTH{1'b0}});

    // Divider FSM with iteration datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            den_q   <= {WIDTH{1'b0}};
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        den_q <= divisor;
                        cnt_q <= {CNT_W{1'b0}};
                        if (zero_div_s) begin
                            state_q <= DONE;
                            quo_q   <= {WIDTH{1'b1}};
                            rem_q   <= dividend;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            dbz_q   <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            quo_q   <= dividend;
                            rem_q   <= {WIDTH{1'b0}};
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            dbz_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN: begin
                    quo_q <= {quo_q[WIDTH-2:0], ~negative_s};
                    rem_q <= negative_s ? trial_x_s[WIDTH-1:0] : trial_diff_s[WIDTH-1:0];
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider8.sv
// Directed and invariant-sweep checks for the 8-bit sequential divider.
module tb_seq_divider8;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_total = 0;
    int n_pass  = 0;

    seq_divider8 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Bounded wait for done; lat counts edges after the start edge.
    task automatic wait_done(input string tag, output int lat, output int bcnt);
        lat  = 0;
        bcnt = int'(busy);
        while (!done && lat < 40) begin
            tick();
            lat++;
            bcnt += int'(busy);
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int eq, input int er, input int edbz,
                             input int elat, input int ebusy);
        int lat;
        int bcnt;
        launch(a, b);
        wait_done(tag, lat, bcnt);
        check({tag, "_quot"}, 32'(quotient), 32'(eq));
        check({tag, "_rem"}, 32'(remainder), 32'(er));
        check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'(edbz));
        check({tag, "_latency"}, 32'(lat), 32'(elat));
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'(ebusy));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_quot"}, 32'(quotient), 32'd0);
        check({tag, "_rem"}, 32'(remainder), 32'd0);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
    endtask

    initial begin
        int lat;
        int bcnt;
        int done_hits;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [31:0]  recon;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_check("d100_7", 8'd100, 8'd7, 14, 2, 0, W, W);
        tick();
        check("d100_7_done_falls", {31'd0, done}, 32'd0);
        check("d100_7_quot_held", 32'(quotient), 32'd14);

        run_check("d37_0", 8'd37, 8'd0, 255, 37, 1, 0, 0);
        tick();
        check("d37_0_done_falls", {31'd0, done}, 32'd0);
        check("d37_0_rem_held", 32'(remainder), 32'd37);

        run_check("d255_1", 8'd255, 8'd1, 255, 0, 0, W, W);
        run_check("d5_9", 8'd5, 8'd9, 0, 5, 0, W, W);
        run_check("d200_200", 8'd200, 8'd200, 1, 0, 0, W, W);

        // Start re-pulsed with new operands while busy must be ignored.
        launch(8'd100, 8'd7);
        tick();
        tick();
        dividend = 8'd50;
        divisor  = 8'd5;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("ignore_still_busy", {31'd0, busy}, 32'd1);
        wait_done("ignore", lat, bcnt);
        check("ignore_quot", 32'(quotient), 32'd14);
        check("ignore_rem", 32'(remainder), 32'd2);
        check("ignore_latency", 32'(lat), 32'd5);

        launch(8'd100, 8'd7);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        done_hits = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            done_hits += int'(done);
        end
        check("midrun_no_done", 32'(done_hits), 32'd0);
        run_check("d81_9", 8'd81, 8'd9, 9, 0, 0, W, W);
        tick();

        // Start held through DONE launches the next run with no idle cycle.
        launch(8'd100, 8'd7);
        wait_done("b2b_first", lat, bcnt);
        check("b2b_first_quot", 32'(quotient), 32'd14);
        dividend = 8'd17;
        divisor  = 8'd4;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        wait_done("b2b_second", lat, bcnt);
        check("b2b_quot", 32'(quotient), 32'd4);
        check("b2b_rem", 32'(remainder), 32'd1);
        check("b2b_latency", 32'(lat), 32'(W));

        for (int k = 0; k < 2000; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            launch(a, b);
            wait_done("sweep", lat, bcnt);
            recon = 32'(quotient) * 32'(b) + 32'(remainder);
            check("sweep_invariant", recon, 32'(a));
            check("sweep_rem_lt_div", {31'd0, (remainder < b)}, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
